// File: rtl/approx_mul_engine_if.sv
// Operand/result handshake bundle for approx_mul_engine.
// Both channels use valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1.
interface approx_mul_engine_if #(
  parameter int DATA_W  = 16,
  parameter int TRUNC_W = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_product;
  logic                  out_exact;
  logic                  busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, out_exact, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, out_exact, busy
  );
endinterface

// File: rtl/approx_mul_engine.sv
// Leading-one-segment approximate multiplier: a serial scan finds each operand's lead bit, then a TRUNC_W x TRUNC_W multiply is shifted back.
// Optional round-to-nearest segment build: define APPROX_MUL_ROUND_EN.
module approx_mul_engine #(
  parameter int DATA_W  = 16,
  parameter int TRUNC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  approx_mul_engine_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_FLOOR = IDX_W'(TRUNC_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   reg_a, reg_b;
  logic [IDX_W-1:0]    idx_a, idx_b;
  logic                done_a, done_b;
  logic [PROD_W-1:0]   product_r;
  logic                exact_r;

  // Top TRUNC_W bits starting at the lead index; the rounding build adds the first dropped bit.
  function automatic logic [TRUNC_W-1:0] segment(input logic [DATA_W-1:0] x,
                                                  input logic [IDX_W-1:0]  i);
    logic [IDX_W-1:0]   lo;
    logic [DATA_W-1:0]  sh;
    logic [TRUNC_W-1:0] seg;
    lo  = i - IDX_FLOOR;
    sh  = x >> lo;
    seg = sh[TRUNC_W-1:0];
`ifdef APPROX_MUL_ROUND_EN
    if (lo != '0 && x[lo - 1'b1] && seg != {TRUNC_W{1'b1}})
      seg = seg + 1'b1;
`endif
    return seg;
  endfunction

  function automatic logic dropped_zero(input logic [DATA_W-1:0] x,
                                        input logic [IDX_W-1:0]  i);
    logic [IDX_W-1:0]  lo;
    logic [DATA_W-1:0] mask;
    lo   = i - IDX_FLOOR;
    mask = (DATA_W'(1) << lo) - DATA_W'(1);
    return (x & mask) == '0;
  endfunction

  logic                hit_a, hit_b;
  logic [TRUNC_W-1:0]  seg_a, seg_b;
  logic [IDX_W:0]      shift;
  logic [PROD_W-1:0]   product_c;
  logic                exact_c;

  always_comb begin
    hit_a     = reg_a[idx_a] || (idx_a == IDX_FLOOR);
    hit_b     = reg_b[idx_b] || (idx_b == IDX_FLOOR);
    seg_a     = segment(reg_a, idx_a);
    seg_b     = segment(reg_b, idx_b);
    shift     = {1'b0, idx_a - IDX_FLOOR} + {1'b0, idx_b - IDX_FLOOR};
    product_c = (PROD_W'(seg_a) * PROD_W'(seg_b)) << shift;
    exact_c   = (reg_a == '0) || (reg_b == '0) ||
                (dropped_zero(reg_a, idx_a) && dropped_zero(reg_b, idx_b));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      idx_a     <= IDX_TOP;
      idx_b     <= IDX_TOP;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      product_r <= '0;
      exact_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            reg_a  <= bus.in_a;
            reg_b  <= bus.in_b;
            idx_a  <= IDX_TOP;
            idx_b  <= IDX_TOP;
            done_a <= 1'b0;
            done_b <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // A finished operand keeps its index, which is then its lead index.
          if (!done_a) begin
            if (hit_a) done_a <= 1'b1;
            else       idx_a  <= idx_a - 1'b1;
          end
          if (!done_b) begin
            if (hit_b) done_b <= 1'b1;
            else       idx_b  <= idx_b - 1'b1;
          end
          if ((done_a || hit_a) && (done_b || hit_b))
            state <= CALC;
        end
        CALC: begin
          product_r <= product_c;
          exact_r   <= exact_c;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_product = product_r;
  assign bus.out_exact   = exact_r;
  assign dbg_state       = state;
endmodule

// File: tb/tb_approx_mul_engine.sv
// Directed bench for approx_mul_engine (DATA_W=16, TRUNC_W=8) with hand-computed products, flags and latencies.
module tb_approx_mul_engine;
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int checks;
  int failures;
  logic [31:0] exp_q[$];

  approx_mul_engine_if #(.DATA_W(16), .TRUNC_W(8)) bus ();

  approx_mul_engine #(.DATA_W(16), .TRUNC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] prod, input logic exact, input int lat,
                        input int hold);
    int cyc;
    logic [31:0] exp_p;
    exp_q.push_back(prod);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 16'($urandom_range(0, 65535));
    bus.in_b     = 16'($urandom_range(0, 65535));
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp_p = exp_q.pop_front();
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_product"}, 64'(bus.out_product), 64'(exp_p));
    check({tag, "_exact"}, 64'(bus.out_exact), 64'(exact));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_product"}, 64'(bus.out_product), 64'(exp_p));
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic seen;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_product", 64'(bus.out_product), 64'd0);
    check("rst_exact", 64'(bus.out_exact), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    run_op("ff_x_3", 16'h00FF, 16'h0003, 32'h0000_02FD, 1'b1, 10, 0);
`ifdef APPROX_MUL_ROUND_EN
    run_op("trunc_mix", 16'h1234, 16'h0100, 32'h0012_4000, 1'b0, 9, 5);
`else
    run_op("trunc_mix", 16'h1234, 16'h0100, 32'h0012_2000, 1'b0, 9, 5);
`endif
    run_op("zero_a", 16'h0000, 16'hFFFF, 32'h0000_0000, 1'b1, 10, 0);
    run_op("sat_a", 16'hFF80, 16'h0001, 32'h0000_FF00, 1'b0, 10, 0);
    run_op("pow2", 16'h0100, 16'h0200, 32'h0002_0000, 1'b1, 9, 0);
    run_op("floor", 16'h0080, 16'h0080, 32'h0000_4000, 1'b1, 10, 0);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFE01_0000, 1'b0, 2, 0);

    // Abort a long scan in its fourth cycle.
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h0001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_in_scan", 64'(dbg_state), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_product", 64'(bus.out_product), 64'd0);
    check("abort_exact", 64'(bus.out_exact), 64'd0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);

    run_op("top_bits", 16'h8000, 16'h8000, 32'h4000_0000, 1'b1, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
